reg_id_skid: RTL and testbench
==============================

Name: reg_id_skid

Overview:
- Parametrised IF/ID stage register and successor to the plain stall/flush stage register.
- Carries pc, instruction and branch-prediction bit between fetch and decode.
- Adds valid/ready handshake on both sides, an optional 2-entry skid buffer that breaks the ready path, a configurable flush payload, and saturating stall/flush event counters.
- Sits between the fetch unit (upstream) and the decode unit (downstream).

Parameters:
- addrWidth, 16: pc width in bits.
- INST_W, 32: instruction width in bits.
- FLUSH_INST, 0 (INST_W bits): value driven on out_inst when no valid entry is held.
- SKID, 1: 1 gives a 2-entry skid buffer with registered in_ready; 0 gives a 1-entry stage with combinational in_ready.
- CNT_W, 16: width of the event counters.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous reset, active-high.
- Flush  in  1  discard all held and incoming entries this cycle.
- Stall  in  1  downstream hold; forces the output handshake to not fire.
- in_valid  in  1  upstream beat valid.
- in_ready  out  1  stage can accept a beat.
- pc_in  in  addrWidth  upstream pc.
- inst_in  in  INST_W  upstream instruction.
- BP_taken_in  in  1  upstream predicted-taken bit.
- out_valid  out  1  head entry valid.
- out_ready  in  1  downstream accepts.
- pc_out  out  addrWidth  head pc.
- inst  out  INST_W  head instruction.
- BP_taken  out  1  head prediction bit.
- stall_cnt  out  CNT_W  saturating count of blocked output cycles.
- flush_cnt  out  CNT_W  saturating count of flushes that killed at least one valid entry.

Behaviour:
- Reset: the sampled rst=1 clears everything at the next edge.
  - main_v=0, skid_v=0, stall_cnt=0, flush_cnt=0.
  - Outputs become out_valid=0, pc_out=0, inst=FLUSH_INST, BP_taken=0.
  - in_ready=1 when SKID=1. When SKID=0, in_ready=1 because main_v=0.
- Firing conditions:
  - in_fire = in_valid & in_ready & ~Flush.
  - out_fire = out_valid & out_ready & ~Stall.
- Output payload: comes from the main entry when main_v=1. When main_v=0 the stage drives pc_out=0, inst=FLUSH_INST and BP_taken=0. Output is registered, so there is no combinational path from input to output.
- SKID=1 states (main_v, skid_v):
  - EMPTY (0,0): on in_fire, load main and go to HALF.
  - HALF (1,0):
    - out_fire and in_fire: reload main, stay HALF.
    - out_fire only: go to EMPTY.
    - in_fire only: load skid, go to FULL.
    - neither: hold.
  - FULL (1,1):
    - out_fire: move skid into main, go to HALF.
    - otherwise hold.
    - in_ready=0, so no input is accepted.
  - in_ready = ~skid_v, driven directly from a flop.
  - skid_v=1 with main_v=0 is illegal and must never occur.
- SKID=0: one entry only.
  - in_ready = ~main_v | out_fire (combinational).
  - When both fire in the same cycle, main reloads.
- Flush:
  - Clears main_v and skid_v next cycle and forces the payload to 0/FLUSH_INST/0.
  - A beat offered in the same cycle is dropped; in_fire is gated.
  - Flush has priority over Stall and over out_fire. A head beat presented with out_ready=1 during Flush counts as not fired.
  - in_ready in a Flush cycle reflects the current state only; upstream must also treat the beat as dropped.
- Stall:
  - Blocks output only; input may still fill the skid when SKID=1, or an empty main.
  - Stall=1 with Flush=0 never alters held entries.
- Ordering: beats leave in the order accepted; no duplication, no loss except on Flush.
- stall_cnt: +1 each cycle with out_valid=1 and out_fire=0 and Flush=0; saturates at all-ones.
- flush_cnt: +1 each cycle with Flush=1 and (main_v | skid_v)=1; saturates at all-ones.
- Counters are cleared only by rst.
- Reset mid-operation: rst wins over Flush, Stall and the handshakes. Entries in flight are lost.

Test Plan:
- Streaming, SKID=1: in_valid=1 every cycle with pc 0x0,0x4,0x8,…, out_ready=1 → out_valid from cycle 2, one beat per cycle in order, stall_cnt=0.
- Backpressure: fill with pc 0x10, 0x14, then hold out_ready=0 → in_ready=0 after 2 accepts. Releasing gives 0x10 then 0x14 with no loss; stall_cnt equals the number of blocked cycles.
- Flush in FULL plus Stall=1 plus in_valid with pc 0x20 → next cycle out_valid=0, inst=FLUSH_INST, pc_out=0, 0x20 never appears, flush_cnt=1.
- SKID=0: out_ready toggling 1,0,1 with continuous input → in_ready follows ~main_v|out_fire in the same cycle, and throughput is 1 beat per cycle when out_ready=1.
- Saturation, CNT_W=4: 20 blocked cycles → stall_cnt=15 and holds.
- rst asserted while FULL with Flush=1 → next cycle all zero, counters 0, in_ready=1.

Source files
------------

// File: rtl/reg_id_skid.sv
// IF/ID stage register with valid/ready handshakes on both sides.
// Carries pc, instruction and predicted-taken bit from fetch to decode.
// SKID=1 uses a two-entry buffer so that in_ready comes straight from a flop.
// SKID=0 uses a single entry and a combinational in_ready.
// Two saturating counters record blocked output cycles and flushes that
// killed at least one live entry.
module reg_id_skid #(
    parameter int                addrWidth  = 16,
    parameter int                INST_W     = 32,
    parameter logic [INST_W-1:0] FLUSH_INST = '0,
    parameter int                SKID       = 1,
    parameter int                CNT_W      = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 Flush,
    input  logic                 Stall,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [addrWidth-1:0] pc_in,
    input  logic [INST_W-1:0]    inst_in,
    input  logic                 BP_taken_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [addrWidth-1:0] pc_out,
    output logic [INST_W-1:0]    inst,
    output logic                 BP_taken,
    output logic [CNT_W-1:0]     stall_cnt,
    output logic [CNT_W-1:0]     flush_cnt
);

    localparam int PW = addrWidth + INST_W + 1;

    // Payload that an empty main entry presents on the outputs.
    localparam logic [PW-1:0] FLUSH_PL = {{addrWidth{1'b0}}, FLUSH_INST, 1'b0};

    // Encoding is {main valid, skid valid}; 2'b01 cannot be represented.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        HALF  = 2'b10,
        FULL  = 2'b11
    } state_t;

    state_t          state_reg, state_next;
    logic [PW-1:0]   main_pl_reg, main_pl_next;
    logic [PW-1:0]   skid_pl_reg, skid_pl_next;
    logic [PW-1:0]   in_pl;
    logic            main_v, skid_v;
    logic            head_take, out_fire, in_fire;

    assign main_v = (state_reg != EMPTY);
    assign skid_v = (state_reg == FULL);
    assign in_pl  = {pc_in, inst_in, BP_taken_in};

    // Downstream would take the head this cycle; Flush then cancels the transfer.
    assign head_take = main_v & out_ready & ~Stall;
    assign out_fire  = head_take & ~Flush;
    assign in_fire   = in_valid & in_ready & ~Flush;

    // Outputs come straight from the main entry registers.
    assign out_valid                 = main_v;
    assign {pc_out, inst, BP_taken}  = main_pl_reg;

    // Next occupancy and payload movement for both buffer depths.
    always_comb begin
        state_next   = state_reg;
        main_pl_next = main_pl_reg;
        skid_pl_next = skid_pl_reg;
        if (Flush) begin
            state_next   = EMPTY;
            main_pl_next = FLUSH_PL;
            skid_pl_next = FLUSH_PL;
        end else if (SKID != 0) begin
            case (state_reg)
                EMPTY: begin
                    if (in_fire) begin
                        main_pl_next = in_pl;
                        state_next   = HALF;
                    end
                end
                HALF: begin
                    if (out_fire && in_fire) begin
                        main_pl_next = in_pl;
                    end else if (out_fire) begin
                        main_pl_next = FLUSH_PL;
                        state_next   = EMPTY;
                    end else if (in_fire) begin
                        skid_pl_next = in_pl;
                        state_next   = FULL;
                    end
                end
                FULL: begin
                    if (out_fire) begin
                        main_pl_next = skid_pl_reg;
                        skid_pl_next = FLUSH_PL;
                        state_next   = HALF;
                    end
                end
                default: begin
                    state_next   = EMPTY;
                    main_pl_next = FLUSH_PL;
                    skid_pl_next = FLUSH_PL;
                end
            endcase
        end else begin
            if (in_fire) begin
                main_pl_next = in_pl;
                state_next   = HALF;
            end else if (out_fire) begin
                main_pl_next = FLUSH_PL;
                state_next   = EMPTY;
            end
        end
    end

    // Occupancy and payload registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= EMPTY;
            main_pl_reg <= FLUSH_PL;
            skid_pl_reg <= FLUSH_PL;
        end else begin
            state_reg   <= state_next;
            main_pl_reg <= main_pl_next;
            skid_pl_reg <= skid_pl_next;
        end
    end

    generate
        if (SKID != 0) begin : g_skid
            logic in_ready_reg;

            // Registered ready: accept whenever the skid slot will be free.
            always_ff @(posedge clk) begin
                if (rst) begin
                    in_ready_reg <= 1'b1;
                end else begin
                    in_ready_reg <= (state_next != FULL);
                end
            end

            assign in_ready = in_ready_reg;
        end else begin : g_noskid
            // Single entry: accept when empty or when the head leaves this cycle.
            assign in_ready = ~main_v | head_take;
        end
    endgenerate

    // Index 0 counts blocked output cycles, index 1 counts flushes that hit live entries.
    logic             cnt_inc [2];
    logic [CNT_W-1:0] cnt_val [2];

    assign cnt_inc[0] = main_v & ~out_fire & ~Flush;
    assign cnt_inc[1] = Flush & (main_v | skid_v);

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_cnt
            logic [CNT_W-1:0] cnt_reg;

            // Saturating event counter, cleared only by reset.
            always_ff @(posedge clk) begin
                if (rst) begin
                    cnt_reg <= '0;
                end else if (cnt_inc[gi] && (cnt_reg != {CNT_W{1'b1}})) begin
                    cnt_reg <= cnt_reg + CNT_W'(1);
                end
            end

            assign cnt_val[gi] = cnt_reg;
        end
    endgenerate

    assign stall_cnt = cnt_val[0];
    assign flush_cnt = cnt_val[1];

endmodule

// File: tb/tb_reg_id_skid.sv
// Bench for reg_id_skid: three instances share one stimulus stream.
//   d0: SKID=1, CNT_W=16   d1: SKID=0, CNT_W=16   d2: SKID=1, CNT_W=4
// A list-based model per instance predicts every output each cycle; directed
// literal checks pin the expected behaviour at key points of each scenario.
module tb_reg_id_skid;

    localparam logic [31:0] FI       = 32'h0000_0013;
    localparam logic [48:0] EMPTY_PL = {16'h0000, FI, 1'b0};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        Flush = 1'b0;
    logic        Stall = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [15:0] pc_in = 16'h0;
    logic [31:0] inst_in = 32'h0;
    logic        BP_in = 1'b0;

    logic        ir_w   [3];
    logic        ov_w   [3];
    logic        bp_w   [3];
    logic [15:0] pc_w   [3];
    logic [31:0] inst_w [3];
    logic [15:0] sc_w   [3];
    logic [15:0] fc_w   [3];
    logic [3:0]  sc4, fc4;

    assign sc_w[2] = {12'h000, sc4};
    assign fc_w[2] = {12'h000, fc4};

    always #5 clk = ~clk;

    reg_id_skid #(.addrWidth(16), .INST_W(32), .FLUSH_INST(FI), .SKID(1), .CNT_W(16)) u_dut (
        .clk(clk), .rst(rst), .Flush(Flush), .Stall(Stall),
        .in_valid(in_valid), .in_ready(ir_w[0]),
        .pc_in(pc_in), .inst_in(inst_in), .BP_taken_in(BP_in),
        .out_valid(ov_w[0]), .out_ready(out_ready),
        .pc_out(pc_w[0]), .inst(inst_w[0]), .BP_taken(bp_w[0]),
        .stall_cnt(sc_w[0]), .flush_cnt(fc_w[0])
    );

    reg_id_skid #(.addrWidth(16), .INST_W(32), .FLUSH_INST(FI), .SKID(0), .CNT_W(16)) u_dut0 (
        .clk(clk), .rst(rst), .Flush(Flush), .Stall(Stall),
        .in_valid(in_valid), .in_ready(ir_w[1]),
        .pc_in(pc_in), .inst_in(inst_in), .BP_taken_in(BP_in),
        .out_valid(ov_w[1]), .out_ready(out_ready),
        .pc_out(pc_w[1]), .inst(inst_w[1]), .BP_taken(bp_w[1]),
        .stall_cnt(sc_w[1]), .flush_cnt(fc_w[1])
    );

    reg_id_skid #(.addrWidth(16), .INST_W(32), .FLUSH_INST(FI), .SKID(1), .CNT_W(4)) u_dut4 (
        .clk(clk), .rst(rst), .Flush(Flush), .Stall(Stall),
        .in_valid(in_valid), .in_ready(ir_w[2]),
        .pc_in(pc_in), .inst_in(inst_in), .BP_taken_in(BP_in),
        .out_valid(ov_w[2]), .out_ready(out_ready),
        .pc_out(pc_w[2]), .inst(inst_w[2]), .BP_taken(bp_w[2]),
        .stall_cnt(sc4), .flush_cnt(fc4)
    );

    int n_pass  = 0;
    int n_total = 0;
    bit started = 1'b0;
    bit seen20  = 1'b0;

    // Model state: ordered list of held beats per instance plus event counts.
    logic [48:0] mdat   [3][2];
    int          mcnt   [3];
    int          mstall [3];
    int          mflush [3];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    function automatic int cap_max(input int d);
        return (d == 2) ? 15 : 65535;
    endfunction

    // Whether instance d takes a beat offered now (before this edge's changes).
    function automatic bit m_ready(input int d);
        if (d == 1) return (mcnt[d] == 0) || (out_ready && !Stall);
        return mcnt[d] < 2;
    endfunction

    // Model update at each rising edge from the current inputs.
    always @(posedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (rst) begin
                mcnt[d]   = 0;
                mstall[d] = 0;
                mflush[d] = 0;
            end else if (Flush) begin
                if (mcnt[d] > 0 && mflush[d] < cap_max(d)) mflush[d]++;
                mcnt[d] = 0;
            end else begin
                bit ir, of;
                ir = m_ready(d);
                of = (mcnt[d] > 0) && out_ready && !Stall;
                if (mcnt[d] > 0 && !of && mstall[d] < cap_max(d)) mstall[d]++;
                if (of) begin
                    mdat[d][0] = mdat[d][1];
                    mcnt[d]--;
                end
                if (in_valid && ir) begin
                    mdat[d][mcnt[d]] = {pc_in, inst_in, BP_in};
                    mcnt[d]++;
                end
            end
        end
        if (rst) started = 1'b1;
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (started) begin
            for (int d = 0; d < 3; d++) begin
                logic [48:0] exp_pl;
                exp_pl = (mcnt[d] > 0) ? mdat[d][0] : EMPTY_PL;
                check($sformatf("d%0d out_valid", d), 64'(ov_w[d]), 64'(mcnt[d] > 0));
                check($sformatf("d%0d payload", d), 64'({pc_w[d], inst_w[d], bp_w[d]}), 64'(exp_pl));
                if (!(d == 1 && Flush))
                    check($sformatf("d%0d in_ready", d), 64'(ir_w[d]), 64'(m_ready(d)));
                check($sformatf("d%0d stall_cnt", d), 64'(sc_w[d]), 64'(mstall[d]));
                check($sformatf("d%0d flush_cnt", d), 64'(fc_w[d]), 64'(mflush[d]));
            end
            if (ov_w[0] && pc_w[0] == 16'h0020) seen20 = 1'b1;
            if (ov_w[0] && out_ready && !Stall && !Flush && !rst)
                $display("d0 beat out pc=%04h inst=%08h bp=%0d", pc_w[0], inst_w[0], bp_w[0]);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [15:0] pc);
        in_valid = v;
        pc_in    = pc;
        inst_in  = {16'hC0DE, pc};
        BP_in    = pc[2];
    endtask

    // Mixed handshake vectors: {in_valid, out_ready, Stall, Flush}.
    logic [3:0] mix_tab [13] = '{4'b1100, 4'b1010, 4'b1110, 4'b1000, 4'b0110,
                                 4'b1100, 4'b1101, 4'b1100, 4'b0100, 4'b1011,
                                 4'b1100, 4'b0100, 4'b0100};

    initial begin
        // Reset
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check("reset out_valid", 64'(ov_w[0]), 64'd0);
        check("reset pc_out", 64'(pc_w[0]), 64'd0);
        check("reset inst", 64'(inst_w[0]), 64'h13);
        check("reset in_ready", 64'(ir_w[0]), 64'd1);
        check("reset in_ready skid0", 64'(ir_w[1]), 64'd1);
        check("reset stall_cnt", 64'(sc_w[0]), 64'd0);

        // Streaming: one beat per cycle in order
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 16'(i * 4));
            tick();
            check($sformatf("stream pc %0d", i), 64'(pc_w[0]), 64'(i * 4));
            check($sformatf("stream valid %0d", i), 64'(ov_w[0]), 64'd1);
        end
        drive(1'b0, 16'h0);
        repeat (3) tick();
        check("stream stall_cnt", 64'(sc_w[0]), 64'd0);

        // Backpressure: two accepts then in_ready drops
        out_ready = 1'b0;
        drive(1'b1, 16'h0010);
        tick();
        check("bp first pc", 64'(pc_w[0]), 64'h10);
        check("bp ready after 1", 64'(ir_w[0]), 64'd1);
        drive(1'b1, 16'h0014);
        tick();
        check("bp ready after 2", 64'(ir_w[0]), 64'd0);
        drive(1'b1, 16'h0018);
        tick();
        drive(1'b0, 16'h0);
        tick();
        tick();
        check("bp stall_cnt", 64'(sc_w[0]), 64'd4);
        check("bp head 0x10", 64'(pc_w[0]), 64'h10);
        out_ready = 1'b1;
        tick();
        check("bp head 0x14", 64'(pc_w[0]), 64'h14);
        check("bp stall_cnt hold", 64'(sc_w[0]), 64'd4);
        tick();
        check("bp drained", 64'(ov_w[0]), 64'd0);

        // Flush while FULL with Stall and an incoming beat
        out_ready = 1'b0;
        drive(1'b1, 16'h0030);
        tick();
        drive(1'b1, 16'h0034);
        tick();
        Flush = 1'b1;
        Stall = 1'b1;
        drive(1'b1, 16'h0020);
        tick();
        Flush = 1'b0;
        Stall = 1'b0;
        drive(1'b0, 16'h0);
        check("flush out_valid", 64'(ov_w[0]), 64'd0);
        check("flush inst", 64'(inst_w[0]), 64'h13);
        check("flush pc_out", 64'(pc_w[0]), 64'd0);
        check("flush flush_cnt", 64'(fc_w[0]), 64'd1);
        out_ready = 1'b1;
        tick();
        tick();
        check("flush nothing surfaces", 64'(ov_w[0]), 64'd0);

        // Single-entry stage: combinational ready and full throughput
        drive(1'b1, 16'h0040);
        tick();
        out_ready = 1'b0;
        #1;
        check("skid0 ready blocked", 64'(ir_w[1]), 64'd0);
        out_ready = 1'b1;
        #1;
        check("skid0 ready passthru", 64'(ir_w[1]), 64'd1);
        drive(1'b1, 16'h0044);
        tick();
        check("skid0 reload 0x44", 64'(pc_w[1]), 64'h44);
        drive(1'b1, 16'h0048);
        out_ready = 1'b0;
        tick();
        check("skid0 hold 0x44", 64'(pc_w[1]), 64'h44);
        drive(1'b1, 16'h004C);
        out_ready = 1'b1;
        tick();
        check("skid0 reload 0x4c", 64'(pc_w[1]), 64'h4C);
        drive(1'b0, 16'h0);
        repeat (3) tick();

        // Mixed handshake, Stall and Flush vectors
        for (int k = 0; k < 13; k++) begin
            logic [3:0] v;
            v = mix_tab[k];
            drive(v[3], 16'(16'h0100 + k * 4));
            out_ready = v[2];
            Stall     = v[1];
            Flush     = v[0];
            tick();
        end
        Stall = 1'b0;
        Flush = 1'b0;
        drive(1'b0, 16'h0);
        out_ready = 1'b1;
        repeat (3) tick();

        // Counter saturation on the 4-bit instance
        out_ready = 1'b0;
        drive(1'b1, 16'h0080);
        tick();
        drive(1'b0, 16'h0);
        repeat (20) tick();
        check("sat stall_cnt", 64'(sc4), 64'd15);
        tick();
        check("sat stall_cnt holds", 64'(sc4), 64'd15);

        // Reset while FULL and flushing
        drive(1'b1, 16'h0084);
        tick();
        check("pre-reset full", 64'(ir_w[0]), 64'd0);
        rst   = 1'b1;
        Flush = 1'b1;
        drive(1'b1, 16'h0088);
        tick();
        rst   = 1'b0;
        Flush = 1'b0;
        drive(1'b0, 16'h0);
        check("rst out_valid", 64'(ov_w[0]), 64'd0);
        check("rst pc_out", 64'(pc_w[0]), 64'd0);
        check("rst inst", 64'(inst_w[0]), 64'h13);
        check("rst bp", 64'(bp_w[0]), 64'd0);
        check("rst stall_cnt", 64'(sc_w[0]), 64'd0);
        check("rst flush_cnt", 64'(fc_w[0]), 64'd0);
        check("rst in_ready", 64'(ir_w[0]), 64'd1);
        tick();
        tick();
        check("pc 0x20 never out", 64'(seen20), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
